// File: rtl/ecg_rate_scheduler.sv
// Heart-rate scheduler for the ECG generator: turns a BPM setpoint into the phase
// accumulator step and slews the rate by at most RAMP_BPM per beat, only at beat boundaries.
module ecg_rate_scheduler #(
  parameter logic [31:0] STEP_PER_BPM = 32'd1491,
  parameter logic [7:0]  DEFAULT_BPM  = 8'd60,
  parameter logic [7:0]  BPM_MIN      = 8'd30,
  parameter logic [7:0]  BPM_MAX      = 8'd240,
  parameter logic [7:0]  RAMP_BPM     = 8'd10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [7:0]  bpm_in,
  input  logic        bpm_valid,
  output logic        bpm_ready,
  input  logic        phase_msb,
  output logic [31:0] phase_step,
  output logic [7:0]  cur_bpm,
  output logic        beat_pulse,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_BEAT, S_STEP, S_UPDATE} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_cur_bpm;
  logic [7:0]  r_target;
  logic [31:0] r_phase_step;
  logic        r_beat_pulse;
  logic        r_msb_d;
  logic        r_en_d;
  logic        w_wrap;
  logic        w_xfer;
  logic [7:0]  w_bpm_clamped;

  function automatic logic [7:0] clamp_bpm(input logic [7:0] b);
    if (b < BPM_MIN)      return BPM_MIN;
    else if (b > BPM_MAX) return BPM_MAX;
    else                  return b;
  endfunction

  // Difference taken 9-bit signed so a downward ramp never wraps.
  function automatic logic [7:0] ramp_bpm(input logic [7:0] cur, input logic [7:0] tgt);
    logic signed [8:0] diff;
    logic signed [8:0] lim;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    lim  = $signed({1'b0, RAMP_BPM});
    if (diff > lim)       return cur + RAMP_BPM;
    else if (diff < -lim) return cur - RAMP_BPM;
    else                  return tgt;
  endfunction

  function automatic logic [31:0] bpm_to_step(input logic [7:0] b);
    return {24'd0, b} * STEP_PER_BPM;
  endfunction

  assign w_wrap        = r_msb_d & ~phase_msb;
  assign w_xfer        = bpm_valid & bpm_ready;
  assign w_bpm_clamped = clamp_bpm(bpm_in);

  always_ff @(posedge clk) begin
    if (!rst_n)      r_state <= S_IDLE;
    else if (enable) r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:      if (w_xfer && (w_bpm_clamped != r_cur_bpm)) w_state_next = S_WAIT_BEAT;
      S_WAIT_BEAT: if (w_wrap) w_state_next = S_STEP;
      S_STEP:      w_state_next = S_UPDATE;
      S_UPDATE:    w_state_next = (r_cur_bpm == r_target) ? S_IDLE : S_WAIT_BEAT;
      default:     w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    bpm_ready = (r_state == S_IDLE) & enable;
    busy      = (r_state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cur_bpm    <= DEFAULT_BPM;
      r_target     <= DEFAULT_BPM;
      r_phase_step <= bpm_to_step(DEFAULT_BPM);
      r_beat_pulse <= 1'b0;
      r_msb_d      <= 1'b0;
      r_en_d       <= 1'b1;
    end else begin
      r_msb_d      <= phase_msb;
      r_en_d       <= enable;
      r_beat_pulse <= enable & w_wrap;
      if (w_xfer) r_target <= w_bpm_clamped;
      if (enable && (r_state == S_STEP)) r_cur_bpm <= ramp_bpm(r_cur_bpm, r_target);
      // Reload on re-enable as well as on UPDATE so a flatline resumes at the held rate.
      if (!enable)
        r_phase_step <= 32'd0;
      else if (!r_en_d || (r_state == S_UPDATE))
        r_phase_step <= bpm_to_step(r_cur_bpm);
    end
  end

  assign phase_step = r_phase_step;
  assign cur_bpm    = r_cur_bpm;
  assign beat_pulse = r_beat_pulse;

endmodule

// File: tb/tb_ecg_rate_scheduler.sv
// Directed bench for ecg_rate_scheduler: reset, ramping, clamping, handshake hold,
// same-cycle wrap/transfer, enable gating and reset in the middle of a ramp.
module tb_ecg_rate_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [7:0]  bpm_in;
  logic        bpm_valid;
  logic        bpm_ready;
  logic        phase_msb;
  logic [31:0] phase_step;
  logic [7:0]  cur_bpm;
  logic        beat_pulse;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  ecg_rate_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .bpm_in     (bpm_in),
    .bpm_valid  (bpm_valid),
    .bpm_ready  (bpm_ready),
    .phase_msb  (phase_msb),
    .phase_step (phase_step),
    .cur_bpm    (cur_bpm),
    .beat_pulse (beat_pulse),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full beat: raise msb, drop it (wrap), then wait until the UPDATE result is visible.
  task automatic run_beat();
    phase_msb = 1'b1; tick();
    phase_msb = 1'b0; tick();
    tick(); tick();
  endtask

  task automatic send_bpm(input logic [7:0] b);
    bpm_in = b; bpm_valid = 1'b1; tick();
    bpm_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick(); tick();
    rst_n = 1'b1;
    n_cmp++; if (phase_step !== 32'd89460) begin n_err++; $display("FAIL reset_step got %0d want 89460", phase_step); end
    n_cmp++; if (cur_bpm !== 8'd60) begin n_err++; $display("FAIL reset_cur got %0d want 60", cur_bpm); end
    n_cmp++; if (bpm_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", bpm_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (beat_pulse !== 1'b0) begin n_err++; $display("FAIL reset_beat got %b want 0", beat_pulse); end
  endtask

  task automatic test_beat_pulse();
    phase_msb = 1'b1; tick();
    phase_msb = 1'b0;
    n_cmp++; if (beat_pulse !== 1'b0) begin n_err++; $display("FAIL beat_early got %b want 0", beat_pulse); end
    tick();
    n_cmp++; if (beat_pulse !== 1'b1) begin n_err++; $display("FAIL beat_high got %b want 1", beat_pulse); end
    tick();
    n_cmp++; if (beat_pulse !== 1'b0) begin n_err++; $display("FAIL beat_one_cycle got %b want 0", beat_pulse); end
    n_cmp++; if (cur_bpm !== 8'd60 || busy !== 1'b0) begin n_err++; $display("FAIL idle_wrap got cur=%0d busy=%b want 60/0", cur_bpm, busy); end
  endtask

  task automatic test_ramp_up();
    logic [31:0] prev;
    logic [7:0]  exp_bpm;
    send_bpm(8'd100);
    n_cmp++; if (busy !== 1'b1 || bpm_ready !== 1'b0) begin n_err++; $display("FAIL ramp_start got busy=%b ready=%b want 1/0", busy, bpm_ready); end
    prev = 32'd89460;
    for (int i = 0; i < 4; i++) begin
      exp_bpm = 8'(70 + 10 * i);
      phase_msb = 1'b1; tick();
      phase_msb = 1'b0; tick();
      tick();
      n_cmp++; if (cur_bpm !== exp_bpm) begin n_err++; $display("FAIL ramp_cur[%0d] got %0d want %0d", i, cur_bpm, exp_bpm); end
      n_cmp++; if (phase_step !== prev) begin n_err++; $display("FAIL ramp_step_early[%0d] got %0d want %0d", i, phase_step, prev); end
      tick();
      prev = 32'(exp_bpm) * 32'd1491;
      n_cmp++; if (phase_step !== prev) begin n_err++; $display("FAIL ramp_step[%0d] got %0d want %0d", i, phase_step, prev); end
    end
    n_cmp++; if (busy !== 1'b0 || bpm_ready !== 1'b1) begin n_err++; $display("FAIL ramp_done got busy=%b ready=%b want 0/1", busy, bpm_ready); end
  endtask

  task automatic test_clamp();
    send_bpm(8'd95);
    run_beat();
    n_cmp++; if (cur_bpm !== 8'd95 || phase_step !== 32'd141645 || busy !== 1'b0) begin
      n_err++; $display("FAIL small_step got cur=%0d step=%0d busy=%b want 95/141645/0", cur_bpm, phase_step, busy); end
    send_bpm(8'd250);
    for (int i = 0; i < 15; i++) run_beat();
    n_cmp++; if (cur_bpm !== 8'd240 || phase_step !== 32'd357840 || busy !== 1'b0) begin
      n_err++; $display("FAIL clamp_hi got cur=%0d step=%0d busy=%b want 240/357840/0", cur_bpm, phase_step, busy); end
    send_bpm(8'd240);
    n_cmp++; if (busy !== 1'b0 || phase_step !== 32'd357840) begin n_err++; $display("FAIL repeat_setpoint got busy=%b step=%0d want 0/357840", busy, phase_step); end
    send_bpm(8'd0);
    for (int i = 0; i < 21; i++) run_beat();
    n_cmp++; if (cur_bpm !== 8'd30 || phase_step !== 32'd44730 || busy !== 1'b0) begin
      n_err++; $display("FAIL clamp_lo got cur=%0d step=%0d busy=%b want 30/44730/0", cur_bpm, phase_step, busy); end
  endtask

  task automatic test_hold_valid();
    send_bpm(8'd50);
    bpm_in = 8'd35; bpm_valid = 1'b1;
    tick(); tick();
    n_cmp++; if (bpm_ready !== 1'b0) begin n_err++; $display("FAIL hold_ready got %b want 0", bpm_ready); end
    run_beat();
    n_cmp++; if (cur_bpm !== 8'd40) begin n_err++; $display("FAIL hold_cur1 got %0d want 40", cur_bpm); end
    run_beat();
    n_cmp++; if (cur_bpm !== 8'd50 || busy !== 1'b0 || bpm_ready !== 1'b1) begin
      n_err++; $display("FAIL hold_cur2 got cur=%0d busy=%b ready=%b want 50/0/1", cur_bpm, busy, bpm_ready); end
    tick();
    bpm_valid = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL hold_xfer got busy=%b want 1", busy); end
    run_beat(); run_beat();
    n_cmp++; if (cur_bpm !== 8'd35 || busy !== 1'b0) begin n_err++; $display("FAIL hold_down got cur=%0d busy=%b want 35/0", cur_bpm, busy); end
  endtask

  task automatic test_same_cycle_wrap();
    phase_msb = 1'b1; tick();
    phase_msb = 1'b0; bpm_in = 8'd45; bpm_valid = 1'b1;
    tick();
    bpm_valid = 1'b0;
    tick(); tick(); tick();
    n_cmp++; if (cur_bpm !== 8'd35 || busy !== 1'b1) begin n_err++; $display("FAIL same_cycle_ignored got cur=%0d busy=%b want 35/1", cur_bpm, busy); end
    run_beat();
    n_cmp++; if (cur_bpm !== 8'd45 || phase_step !== 32'd67095) begin n_err++; $display("FAIL same_cycle_next got cur=%0d step=%0d want 45/67095", cur_bpm, phase_step); end
  endtask

  task automatic test_enable();
    send_bpm(8'd75);
    run_beat();
    n_cmp++; if (cur_bpm !== 8'd55 || phase_step !== 32'd82005) begin n_err++; $display("FAIL en_pre got cur=%0d step=%0d want 55/82005", cur_bpm, phase_step); end
    enable = 1'b0; tick();
    n_cmp++; if (phase_step !== 32'd0 || bpm_ready !== 1'b0 || busy !== 1'b1) begin
      n_err++; $display("FAIL en_off got step=%0d ready=%b busy=%b want 0/0/1", phase_step, bpm_ready, busy); end
    phase_msb = 1'b1; tick();
    phase_msb = 1'b0; tick();
    n_cmp++; if (beat_pulse !== 1'b0) begin n_err++; $display("FAIL en_off_beat got %b want 0", beat_pulse); end
    tick(); tick();
    n_cmp++; if (cur_bpm !== 8'd55 || phase_step !== 32'd0) begin n_err++; $display("FAIL en_off_frozen got cur=%0d step=%0d want 55/0", cur_bpm, phase_step); end
    enable = 1'b1; tick();
    n_cmp++; if (phase_step !== 32'd82005) begin n_err++; $display("FAIL en_restore got %0d want 82005", phase_step); end
    run_beat();
    n_cmp++; if (cur_bpm !== 8'd65 || phase_step !== 32'd96915) begin n_err++; $display("FAIL en_resume got cur=%0d step=%0d want 65/96915", cur_bpm, phase_step); end
  endtask

  task automatic test_reset_mid_ramp();
    phase_msb = 1'b1; tick();
    phase_msb = 1'b0; tick();
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
    n_cmp++; if (cur_bpm !== 8'd60 || phase_step !== 32'd89460) begin n_err++; $display("FAIL mid_reset got cur=%0d step=%0d want 60/89460", cur_bpm, phase_step); end
    n_cmp++; if (busy !== 1'b0 || bpm_ready !== 1'b1 || beat_pulse !== 1'b0) begin
      n_err++; $display("FAIL mid_reset_ctl got busy=%b ready=%b beat=%b want 0/1/0", busy, bpm_ready, beat_pulse); end
    run_beat();
    n_cmp++; if (cur_bpm !== 8'd60 || busy !== 1'b0) begin n_err++; $display("FAIL mid_reset_idle got cur=%0d busy=%b want 60/0", cur_bpm, busy); end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; bpm_in = 8'd0; bpm_valid = 1'b0; phase_msb = 1'b0;
    test_reset();
    test_beat_pulse();
    test_ramp_up();
    test_clamp();
    test_hold_valid();
    test_same_cycle_wrap();
    test_enable();
    test_reset_mid_ramp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ecg_rate_scheduler.md
Name: ecg_rate_scheduler

Overview:
- Sets the heart rate of the ECG waveform generator: converts a BPM setpoint into the 32-bit `phase_step` that drives the generator's phase accumulator.
- Changes rate only at beat boundaries, detected when the phase-address MSB wraps, so the waveform never jumps mid-complex.
- Slews the rate by a bounded BPM amount per beat, giving a smooth, glitch-free tempo change.
- Sits between the control/register interface and the generator's `phase_step` input.

Parameters:
- STEP_PER_BPM, 1491, phase_step increment per 1 BPM (2^32 / (60 × 48 kHz), truncated).
- DEFAULT_BPM, 60, rate after reset.
- BPM_MIN, 30, lower clamp for accepted setpoints.
- BPM_MAX, 240, upper clamp for accepted setpoints.
- RAMP_BPM, 10, maximum |change| of current BPM per beat boundary.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- enable  in  1  1 = generate; 0 = flatline (phase_step forced to 0).
- bpm_in  in  8  requested BPM (unsigned).
- bpm_valid  in  1  setpoint request.
- bpm_ready  out  1  setpoint can be accepted.
- phase_msb  in  1  MSB of the generator's 10-bit phase address.
- phase_step  out  32  step to the phase accumulator (registered).
- cur_bpm  out  8  BPM currently applied.
- beat_pulse  out  1  one-cycle pulse per beat boundary.
- busy  out  1  ramp in progress (cur_bpm != target).

Behaviour:
- Reset (rst_n=0 at a clk edge) forces:
  - cur_bpm=target=DEFAULT_BPM; phase_step=DEFAULT_BPM×STEP_PER_BPM (89460); bpm_ready=1; busy=0; beat_pulse=0; msb_d=0; FSM=IDLE.
  - Reset mid-ramp abandons the ramp and applies the same defaults.
- Beat detect:
  - msb_d registers phase_msb every cycle.
  - wrap = msb_d & ~phase_msb.
  - beat_pulse is registered and goes high the cycle after wrap, only when enable=1.
- Setpoint handshake:
  - bpm_ready = (FSM==IDLE) & enable.
  - Transfer occurs when bpm_valid & bpm_ready at a clk edge.
  - target = clamp(bpm_in, BPM_MIN, BPM_MAX); bpm_in=0 gives BPM_MIN.
  - Requests while not ready are ignored; the requester holds bpm_valid until ready.
- FSM:
  - IDLE: on transfer, go to WAIT_BEAT if the clamped target != cur_bpm, else stay in IDLE. A wrap in the same cycle as the transfer is not consumed.
  - WAIT_BEAT: on wrap, go to STEP.
  - STEP (1 cycle): cur_bpm moves toward target by min(|target−cur_bpm|, RAMP_BPM), then go to UPDATE.
  - UPDATE (1 cycle): phase_step = cur_bpm × STEP_PER_BPM (8×32 unsigned product, low 32 bits). Go to IDLE if cur_bpm==target, else to WAIT_BEAT.
- Latency:
  - phase_step changes 3 clk edges after the cycle in which wrap is high.
  - The step is applied within the first samples of the new beat.
- busy = (FSM != IDLE).
- enable=0:
  - Next edge: phase_step=0.
  - FSM frozen; cur_bpm and target held; bpm_ready=0; beat_pulse=0.
  - On enable returning to 1, phase_step reloads to cur_bpm×STEP_PER_BPM on the next edge and the FSM resumes from its held state.
- Arithmetic:
  - BPM math is unsigned 8-bit. The difference is computed 9-bit signed, so there is no wrap.
  - cur_bpm never leaves [BPM_MIN, BPM_MAX] after the first accepted setpoint.
- A repeated setpoint equal to cur_bpm leaves the FSM in IDLE with no phase_step change.

Test Plan:
- Reset → phase_step=89460, cur_bpm=60, bpm_ready=1, busy=0. Toggle phase_msb 1→0 → beat_pulse high for exactly 1 cycle, 1 cycle after the wrap.
- Accept bpm_in=100 → busy=1. cur_bpm takes 70, 80, 90, 100 on four successive wraps. phase_step takes 104370, 119280, 134190, 149100, each 3 edges after its wrap. After the last, busy=0 and bpm_ready=1.
- bpm_in=250 → target 240. bpm_in=0 → target 30. From 100, a 95 request finishes in one beat: phase_step=141645.
- Hold bpm_valid during a ramp → no transfer until IDLE. Transfer and wrap in the same cycle → that wrap is ignored and cur_bpm changes at the next wrap.
- enable=0 mid-ramp → phase_step=0 next edge, beat_pulse silent, bpm_ready=0. enable=1 → phase_step restored, ramp continues from the held cur_bpm.
- Assert rst_n=0 during STEP → after reset, cur_bpm=60, phase_step=89460, FSM=IDLE.
